// File: rtl/csr_exec_pipe.sv
// rtl/csr_exec_pipe.sv - registered CSR read-modify-write unit with PMP routing and response FIFO
module csr_exec_pipe #(
    parameter int XLEN                  = 64,
    parameter int ROB_INDEX_WIDTH       = 4,
    parameter int PHY_REG_ADDR_WIDTH    = 6,
    parameter int CSR_ADDR_LEN          = 12,
    parameter int IMM_LEN               = 5,
    parameter int EXCEPTION_CAUSE_WIDTH = 4,
    parameter int PMP_ENTRIES           = 16,
    parameter int RESP_DEPTH            = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic [ROB_INDEX_WIDTH-1:0]           rob_index_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0]        prd_addr_i,
    input  logic [2:0]                           func3_i,
    input  logic [XLEN-1:0]                      prs1_data_i,
    input  logic                                 rs1_is_x0_i,
    input  logic [IMM_LEN-1:0]                   imm_i,
    input  logic [CSR_ADDR_LEN-1:0]              csr_addr_i,
    input  logic                                 csr_do_read_i,
    input  logic                                 csr_do_write_i,
    input  logic                                 flush_i,
    output logic [CSR_ADDR_LEN-1:0]              csr_raddr_o,
    input  logic [XLEN-1:0]                      csr_rdata_i,
    input  logic                                 csr_readable_i,
    input  logic                                 csr_writable_i,
    output logic                                 csr_wen_o,
    output logic [CSR_ADDR_LEN-1:0]              csr_waddr_o,
    output logic [XLEN-1:0]                      csr_wdata_o,
    output logic                                 pmp_cfg_vld_o,
    output logic [$clog2(PMP_ENTRIES/8):0]       pmp_cfg_addr_o,
    output logic [XLEN-1:0]                      pmp_cfg_payload_o,
    input  logic [XLEN-1:0]                      pmp_cfg_origin_payload_i,
    output logic                                 pmp_addr_vld_o,
    output logic [$clog2(PMP_ENTRIES)-1:0]       pmp_addr_addr_o,
    output logic [XLEN-1:0]                      pmp_addr_payload_o,
    input  logic [XLEN-1:0]                      pmp_addr_origin_payload_i,
    output logic                                 resp_valid_o,
    input  logic                                 resp_ready_i,
    output logic [ROB_INDEX_WIDTH-1:0]           resp_rob_index_o,
    output logic [PHY_REG_ADDR_WIDTH-1:0]        resp_prd_addr_o,
    output logic [XLEN-1:0]                      resp_data_o,
    output logic                                 resp_exception_o,
    output logic [EXCEPTION_CAUSE_WIDTH-1:0]     resp_ecause_o
);

    localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
    localparam int CFG_AW = $clog2(PMP_ENTRIES/8) + 1;
    localparam int PA_AW  = $clog2(PMP_ENTRIES);
    localparam logic [CSR_ADDR_LEN-1:0] CFG_BASE = CSR_ADDR_LEN'('h3A0);
    localparam logic [CSR_ADDR_LEN-1:0] CFG_END  = CSR_ADDR_LEN'('h3A0 + PMP_ENTRIES/4);
    localparam logic [CSR_ADDR_LEN-1:0] PA_BASE  = CSR_ADDR_LEN'('h3B0);
    localparam logic [CSR_ADDR_LEN-1:0] PA_END   = CSR_ADDR_LEN'('h3B0 + PMP_ENTRIES);

    typedef enum logic {S_IDLE, S_EXEC} state_t;

    typedef struct packed {
        logic [ROB_INDEX_WIDTH-1:0]    rob;
        logic [PHY_REG_ADDR_WIDTH-1:0] prd;
        logic [2:0]                    func3;
        logic [XLEN-1:0]               rs1;
        logic                          rs1_x0;
        logic [IMM_LEN-1:0]            imm;
        logic [CSR_ADDR_LEN-1:0]       addr;
        logic                          do_read;
        logic                          do_write;
    } req_t;

    typedef struct packed {
        logic [ROB_INDEX_WIDTH-1:0]       rob;
        logic [PHY_REG_ADDR_WIDTH-1:0]    prd;
        logic [XLEN-1:0]                  data;
        logic                             exc;
        logic [EXCEPTION_CAUSE_WIDTH-1:0] ecause;
    } resp_t;

    state_t                state_q, state_d;
    req_t                  req_q, req_d;
    resp_t                 mem_q [RESP_DEPTH];
    resp_t                 mem_d [RESP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  exec, is_cfg, is_pa, eff_wr, illegal, commit, push, pop, accept;
    logic [XLEN-1:0]       old_val, new_val, zimm;
    resp_t                 push_entry, head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign exec        = (state_q == S_EXEC);
    assign req_ready_o = (state_q == S_IDLE) && (count_q < CNT_W'(RESP_DEPTH));
    assign accept      = req_valid_i && req_ready_o && !flush_i;

    // Next state and request capture; flush wins over a handshake in the same cycle
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else if (exec) begin
            state_d = S_IDLE;
        end else if (accept) begin
            state_d      = S_EXEC;
            req_d.rob    = rob_index_i;
            req_d.prd    = prd_addr_i;
            req_d.func3  = func3_i;
            req_d.rs1    = prs1_data_i;
            req_d.rs1_x0 = rs1_is_x0_i;
            req_d.imm    = imm_i;
            req_d.addr   = csr_addr_i;
            req_d.do_read  = csr_do_read_i;
            req_d.do_write = csr_do_write_i;
        end
    end

    // Execute-cycle decode, legality check and read-modify-write value
    always_comb begin
        is_cfg  = (req_q.addr >= CFG_BASE) && (req_q.addr < CFG_END);
        is_pa   = (req_q.addr >= PA_BASE) && (req_q.addr < PA_END);
        old_val = is_cfg ? pmp_cfg_origin_payload_i :
                  is_pa  ? pmp_addr_origin_payload_i : csr_rdata_i;
        zimm    = XLEN'(req_q.imm);
        eff_wr  = req_q.do_write;
        if ((req_q.func3 == 3'b010 || req_q.func3 == 3'b011) && req_q.rs1_x0)
            eff_wr = 1'b0;
        if ((req_q.func3 == 3'b110 || req_q.func3 == 3'b111) && req_q.imm == '0)
            eff_wr = 1'b0;
        illegal = (req_q.func3 == 3'b000) || (req_q.func3 == 3'b100)
                || (req_q.do_read && !csr_readable_i)
                || (eff_wr && !csr_writable_i)
                || ((XLEN == 64) && is_cfg && req_q.addr[0]);
        case (req_q.func3)
            3'b001:  new_val = req_q.rs1;
            3'b010:  new_val = old_val | req_q.rs1;
            3'b011:  new_val = old_val & ~req_q.rs1;
            3'b101:  new_val = zimm;
            3'b110:  new_val = old_val | zimm;
            3'b111:  new_val = old_val & ~zimm;
            default: new_val = '0;
        endcase
        commit = exec && eff_wr && !illegal && !flush_i;
        push   = exec && !flush_i;
        push_entry.rob    = req_q.rob;
        push_entry.prd    = req_q.prd;
        push_entry.data   = illegal ? '0 : old_val;
        push_entry.exc    = illegal;
        push_entry.ecause = illegal ? EXCEPTION_CAUSE_WIDTH'(2) : '0;
    end

    // Commit strobes and payloads, quiet outside the execute cycle
    always_comb begin
        csr_raddr_o        = req_q.addr;
        csr_wen_o          = commit && !is_cfg && !is_pa;
        pmp_cfg_vld_o      = commit && is_cfg;
        pmp_addr_vld_o     = commit && is_pa;
        csr_waddr_o        = exec ? req_q.addr : '0;
        csr_wdata_o        = exec ? new_val : '0;
        pmp_cfg_payload_o  = exec ? new_val : '0;
        pmp_addr_payload_o = exec ? new_val : '0;
        pmp_cfg_addr_o     = (exec && is_cfg) ? CFG_AW'((req_q.addr - CFG_BASE) >> 1) : '0;
        pmp_addr_addr_o    = (exec && is_pa) ? PA_AW'(req_q.addr - PA_BASE) : '0;
    end

    // Response FIFO bookkeeping; flush empties it regardless of push/pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop      = (count_q != '0) && resp_ready_i;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Head of FIFO drives the response port, zeroed when empty
    always_comb begin
        resp_valid_o     = (count_q != '0);
        head             = resp_valid_o ? mem_q[rd_ptr_q] : '0;
        resp_rob_index_o = head.rob;
        resp_prd_addr_o  = head.prd;
        resp_data_o      = head.data;
        resp_exception_o = head.exc;
        resp_ecause_o    = head.ecause;
    end

    // Control and latched request registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RESP_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_csr_exec_pipe.sv
// tb/tb_csr_exec_pipe.sv - table, hand-sequence and random checks for csr_exec_pipe
module tb_csr_exec_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid_i = 1'b0, req_ready_o;
    logic [3:0]  rob_index_i = '0;
    logic [5:0]  prd_addr_i = '0;
    logic [2:0]  func3_i = '0;
    logic [63:0] prs1_data_i = '0;
    logic        rs1_is_x0_i = 1'b0;
    logic [4:0]  imm_i = '0;
    logic [11:0] csr_addr_i = '0;
    logic        csr_do_read_i = 1'b0, csr_do_write_i = 1'b0, flush_i = 1'b0;
    logic [11:0] csr_raddr_o;
    logic [63:0] csr_rdata_i = '0;
    logic        csr_readable_i = 1'b0, csr_writable_i = 1'b0;
    logic        csr_wen_o;
    logic [11:0] csr_waddr_o;
    logic [63:0] csr_wdata_o;
    logic        pmp_cfg_vld_o;
    logic [1:0]  pmp_cfg_addr_o;
    logic [63:0] pmp_cfg_payload_o, pmp_cfg_origin_payload_i = '0;
    logic        pmp_addr_vld_o;
    logic [3:0]  pmp_addr_addr_o;
    logic [63:0] pmp_addr_payload_o, pmp_addr_origin_payload_i = '0;
    logic        resp_valid_o, resp_ready_i = 1'b0;
    logic [3:0]  resp_rob_index_o;
    logic [5:0]  resp_prd_addr_o;
    logic [63:0] resp_data_o;
    logic        resp_exception_o;
    logic [3:0]  resp_ecause_o;

    csr_exec_pipe dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .rob_index_i(rob_index_i), .prd_addr_i(prd_addr_i), .func3_i(func3_i),
        .prs1_data_i(prs1_data_i), .rs1_is_x0_i(rs1_is_x0_i), .imm_i(imm_i),
        .csr_addr_i(csr_addr_i), .csr_do_read_i(csr_do_read_i), .csr_do_write_i(csr_do_write_i),
        .flush_i(flush_i), .csr_raddr_o(csr_raddr_o), .csr_rdata_i(csr_rdata_i),
        .csr_readable_i(csr_readable_i), .csr_writable_i(csr_writable_i),
        .csr_wen_o(csr_wen_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .pmp_cfg_vld_o(pmp_cfg_vld_o), .pmp_cfg_addr_o(pmp_cfg_addr_o),
        .pmp_cfg_payload_o(pmp_cfg_payload_o), .pmp_cfg_origin_payload_i(pmp_cfg_origin_payload_i),
        .pmp_addr_vld_o(pmp_addr_vld_o), .pmp_addr_addr_o(pmp_addr_addr_o),
        .pmp_addr_payload_o(pmp_addr_payload_o), .pmp_addr_origin_payload_i(pmp_addr_origin_payload_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rob_index_o(resp_rob_index_o), .resp_prd_addr_o(resp_prd_addr_o),
        .resp_data_o(resp_data_o), .resp_exception_o(resp_exception_o), .resp_ecause_o(resp_ecause_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [63:0] rs1;
        logic        x0;
        logic [4:0]  imm;
        logic        rd, wr, rdbl, wrbl;
        logic [63:0] old;
        logic        e_wen, e_cfg, e_pa;
        logic [63:0] e_wdata;
        logic [3:0]  e_sub;
        logic        e_exc;
        logic [63:0] e_data;
        logic [3:0]  rob;
        logic [5:0]  prd;
    } vec_t;

    int pass_cnt = 0;
    int total_cnt = 0;
    vec_t tbl [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
        else pass_cnt++;
    endtask

    function automatic vec_t mk(input int f3, input int addr, input logic [63:0] rs1, input int x0,
                                input int imm, input int rd, input int wr, input int rdbl, input int wrbl,
                                input logic [63:0] old, input int ewen, input int ecfg, input int epa,
                                input logic [63:0] ewd, input int esub, input int eexc, input logic [63:0] edata);
        vec_t v;
        v.f3 = 3'(f3); v.addr = 12'(addr); v.rs1 = rs1; v.x0 = (x0 != 0); v.imm = 5'(imm);
        v.rd = (rd != 0); v.wr = (wr != 0); v.rdbl = (rdbl != 0); v.wrbl = (wrbl != 0); v.old = old;
        v.e_wen = (ewen != 0); v.e_cfg = (ecfg != 0); v.e_pa = (epa != 0); v.e_wdata = ewd;
        v.e_sub = 4'(esub); v.e_exc = (eexc != 0); v.e_data = edata; v.rob = '0; v.prd = '0;
        return v;
    endfunction

    function automatic bit in_cfg(input logic [11:0] a);
        return (a >= 12'h3A0) && (a < 12'h3A4);
    endfunction

    function automatic bit in_pa(input logic [11:0] a);
        return (a >= 12'h3B0) && (a < 12'h3C0);
    endfunction

    // Reference: privileged-spec CSR semantics for XLEN=64, 16 PMP entries
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        bit set_clr_reg = (v.f3 == 3'd2) || (v.f3 == 3'd3);
        bit set_clr_imm = (v.f3 == 3'd6) || (v.f3 == 3'd7);
        bit writes = v.wr && !(set_clr_reg && v.x0) && !(set_clr_imm && v.imm == 0);
        bit cfg = in_cfg(v.addr);
        bit pa = in_pa(v.addr);
        bit bad = (v.f3 == 3'd0) || (v.f3 == 3'd4) || (v.rd && !v.rdbl) || (writes && !v.wrbl)
                  || (cfg && (v.addr % 2 == 1));
        logic [63:0] z = {59'd0, v.imm};
        case (v.f3)
            3'd1: r.e_wdata = v.rs1;
            3'd2: r.e_wdata = v.old | v.rs1;
            3'd3: r.e_wdata = v.old & ~v.rs1;
            3'd5: r.e_wdata = z;
            3'd6: r.e_wdata = v.old | z;
            3'd7: r.e_wdata = v.old & ~z;
            default: r.e_wdata = 64'd0;
        endcase
        r.e_wen  = writes && !bad && !cfg && !pa;
        r.e_cfg  = writes && !bad && cfg;
        r.e_pa   = writes && !bad && pa;
        r.e_sub  = cfg ? 4'((v.addr - 12'h3A0) / 2) : pa ? 4'(v.addr - 12'h3B0) : 4'd0;
        r.e_exc  = bad;
        r.e_data = bad ? 64'd0 : v.old;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        bit cfg = in_cfg(v.addr);
        bit pa = in_pa(v.addr);
        func3_i = v.f3; csr_addr_i = v.addr; prs1_data_i = v.rs1; rs1_is_x0_i = v.x0; imm_i = v.imm;
        csr_do_read_i = v.rd; csr_do_write_i = v.wr; csr_readable_i = v.rdbl; csr_writable_i = v.wrbl;
        rob_index_i = v.rob; prd_addr_i = v.prd;
        csr_rdata_i = (cfg || pa) ? 64'hDEAD_BEEF_0BAD_F00D : v.old;
        pmp_cfg_origin_payload_i  = cfg ? v.old : 64'hC0FF_EE00_1111_2222;
        pmp_addr_origin_payload_i = pa ? v.old : 64'h5555_AAAA_5555_AAAA;
    endtask

    // Issue one request; returns at the falling edge inside its execute cycle
    task automatic send(input vec_t v, input string tag);
        int guard = 0;
        @(negedge clk);
        drive(v);
        req_valid_i = 1'b1;
        while (!req_ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready_o) chk({tag, ".ready_timeout"}, 64'(req_ready_o), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        send(v, tag);
        chk({tag, ".raddr"}, 64'(csr_raddr_o), 64'(v.addr));
        chk({tag, ".wen"}, 64'(csr_wen_o), 64'(v.e_wen));
        chk({tag, ".cfg_vld"}, 64'(pmp_cfg_vld_o), 64'(v.e_cfg));
        chk({tag, ".addr_vld"}, 64'(pmp_addr_vld_o), 64'(v.e_pa));
        if (v.e_wen) begin
            chk({tag, ".wdata"}, csr_wdata_o, v.e_wdata);
            chk({tag, ".waddr"}, 64'(csr_waddr_o), 64'(v.addr));
        end
        if (v.e_cfg) begin
            chk({tag, ".cfg_payload"}, pmp_cfg_payload_o, v.e_wdata);
            chk({tag, ".cfg_addr"}, 64'(pmp_cfg_addr_o), 64'(v.e_sub));
        end
        if (v.e_pa) begin
            chk({tag, ".pa_payload"}, pmp_addr_payload_o, v.e_wdata);
            chk({tag, ".pa_addr"}, 64'(pmp_addr_addr_o), 64'(v.e_sub));
        end
        @(negedge clk);
        chk({tag, ".resp_valid"}, 64'(resp_valid_o), 64'd1);
        chk({tag, ".resp_data"}, resp_data_o, v.e_data);
        chk({tag, ".resp_exc"}, 64'(resp_exception_o), 64'(v.e_exc));
        chk({tag, ".resp_ecause"}, 64'(resp_ecause_o), v.e_exc ? 64'd2 : 64'd0);
        chk({tag, ".resp_rob"}, 64'(resp_rob_index_o), 64'(v.rob));
        chk({tag, ".resp_prd"}, 64'(resp_prd_addr_o), 64'(v.prd));
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
    endtask

    function automatic vec_t simple(input int rob, input int addr, input logic [63:0] old);
        vec_t v = mk(1, addr, 64'h1, 0, 0, 1, 1, 1, 1, old, 1, 0, 0, 64'h1, 0, 0, old);
        v.rob = 4'(rob);
        v.prd = 6'(rob + 8);
        return v;
    endfunction

    initial begin
        vec_t v;
        tbl[0]  = mk(1, 'h300, 64'h5, 0, 0, 1, 1, 1, 1, 64'hA, 1, 0, 0, 64'h5, 0, 0, 64'hA);
        tbl[1]  = mk(2, 'hC00, 64'hFFFF, 1, 0, 1, 1, 1, 0, 64'h1234, 0, 0, 0, 64'h0, 0, 0, 64'h1234);
        tbl[2]  = mk(6, 'hC00, 64'h0, 0, 3, 1, 1, 1, 0, 64'h1234, 0, 0, 0, 64'h0, 0, 1, 64'h0);
        tbl[3]  = mk(1, 'h3A2, 64'h55, 0, 0, 1, 1, 1, 1, 64'h77, 0, 1, 0, 64'h55, 1, 0, 64'h77);
        tbl[4]  = mk(1, 'h3A1, 64'h55, 0, 0, 1, 1, 1, 1, 64'h77, 0, 0, 0, 64'h0, 0, 1, 64'h0);
        tbl[5]  = mk(3, 'h3B5, 64'h0F, 0, 0, 1, 1, 1, 1, 64'hFF, 0, 0, 1, 64'hF0, 5, 0, 64'hFF);
        tbl[6]  = mk(0, 'h300, 64'h1, 0, 0, 1, 1, 1, 1, 64'h9, 0, 0, 0, 64'h0, 0, 1, 64'h0);
        tbl[7]  = mk(7, 'h300, 64'h0, 0, 0, 1, 1, 1, 0, 64'h9, 0, 0, 0, 64'h0, 0, 0, 64'h9);
        tbl[8]  = mk(5, 'h305, 64'h0, 0, 31, 0, 1, 1, 1, 64'h3, 1, 0, 0, 64'h1F, 0, 0, 64'h3);
        tbl[9]  = mk(2, 'h340, 64'h1, 0, 0, 1, 1, 0, 1, 64'h3, 0, 0, 0, 64'h0, 0, 1, 64'h0);
        tbl[10] = mk(4, 'h340, 64'h1, 0, 0, 1, 1, 1, 1, 64'h3, 0, 0, 0, 64'h0, 0, 1, 64'h0);
        tbl[11] = mk(6, 'h340, 64'h0, 0, 5, 1, 1, 1, 1, 64'h10, 1, 0, 0, 64'h15, 0, 0, 64'h10);
        tbl[12] = mk(1, 'h3BF, 64'hABCD, 0, 0, 1, 1, 1, 1, 64'h1, 0, 0, 1, 64'hABCD, 15, 0, 64'h1);
        tbl[13] = mk(3, 'h301, 64'h0, 1, 0, 1, 1, 1, 0, 64'h42, 0, 0, 0, 64'h0, 0, 0, 64'h42);

        // reset values
        #12;
        chk("rst.ready", 64'(req_ready_o), 64'd1);
        chk("rst.resp_valid", 64'(resp_valid_o), 64'd0);
        chk("rst.wen", 64'(csr_wen_o), 64'd0);
        chk("rst.pmp_vld", 64'({pmp_cfg_vld_o, pmp_addr_vld_o}), 64'd0);
        chk("rst.raddr", 64'(csr_raddr_o), 64'd0);
        chk("rst.wdata", csr_wdata_o, 64'd0);
        chk("rst.resp_data", resp_data_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            tbl[i].rob = 4'(i);
            tbl[i].prd = 6'(i * 3);
            run_vec(tbl[i], $sformatf("tbl%0d", i));
        end

        // reset during execute drops the commit strobe at once
        send(simple(1, 'h300, 64'h7), "arst");
        chk("arst.wen_before", 64'(csr_wen_o), 64'd1);
        rst = 1'b0;
        #1;
        chk("arst.wen_dropped", 64'(csr_wen_o), 64'd0);
        chk("arst.resp_valid", 64'(resp_valid_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("arst.ready", 64'(req_ready_o), 64'd1);
        chk("arst.fifo_empty", 64'(resp_valid_o), 64'd0);

        // backpressure: FIFO of 2 fills, third request stalls, order preserved
        send(simple(1, 'h300, 64'h11), "bp1");
        send(simple(2, 'h300, 64'h22), "bp2");
        @(negedge clk);
        drive(simple(3, 'h300, 64'h33));
        req_valid_i = 1'b1;
        chk("bp.stall0", 64'(req_ready_o), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp.stall%0d", k + 1), 64'(req_ready_o), 64'd0);
        end
        chk("bp.head1_rob", 64'(resp_rob_index_o), 64'd1);
        chk("bp.head1_data", resp_data_o, 64'h11);
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
        chk("bp.ready_after_pop", 64'(req_ready_o), 64'd1);
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("bp.head2_rob", 64'(resp_rob_index_o), 64'd2);
        chk("bp.head2_data", resp_data_o, 64'h22);
        resp_ready_i = 1'b1;
        @(negedge clk);
        chk("bp.head3_rob", 64'(resp_rob_index_o), 64'd3);
        chk("bp.head3_data", resp_data_o, 64'h33);
        @(negedge clk);
        resp_ready_i = 1'b0;
        chk("bp.drained", 64'(resp_valid_o), 64'd0);

        // flush during execute with one entry pending
        send(simple(4, 'h300, 64'h44), "fl1");
        send(simple(5, 'h305, 64'h55), "fl2");
        flush_i = 1'b1;
        #1;
        chk("fl.no_commit", 64'(csr_wen_o), 64'd0);
        @(negedge clk);
        flush_i = 1'b0;
        chk("fl.resp_valid", 64'(resp_valid_o), 64'd0);
        chk("fl.ready", 64'(req_ready_o), 64'd1);
        // flush beats a simultaneous handshake
        drive(simple(6, 'h341, 64'h66));
        req_valid_i = 1'b1;
        flush_i = 1'b1;
        @(negedge clk);
        req_valid_i = 1'b0;
        flush_i = 1'b0;
        chk("fl.dropped_wen", 64'(csr_wen_o), 64'd0);
        chk("fl.dropped_raddr", 64'(csr_raddr_o), 64'h305);
        chk("fl.dropped_ready", 64'(req_ready_o), 64'd1);
        run_vec(tbl[0], "fl.after");

        // randomized requests against the reference model
        for (int i = 0; i < 150; i++) begin
            int sel = $urandom_range(0, 3);
            v.f3 = 3'($urandom_range(0, 7));
            v.addr = (sel == 0) ? 12'(12'h300 + $urandom_range(0, 15)) :
                     (sel == 1) ? 12'(12'h3A0 + $urandom_range(0, 3)) :
                     (sel == 2) ? 12'(12'h3B0 + $urandom_range(0, 15)) : 12'($urandom);
            v.rs1 = {$urandom, $urandom};
            v.old = {$urandom, $urandom};
            v.x0 = ($urandom_range(0, 3) == 0);
            v.imm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            v.rd = 1'($urandom);
            v.wr = 1'($urandom);
            v.rdbl = ($urandom_range(0, 7) != 0);
            v.wrbl = ($urandom_range(0, 5) != 0);
            v.rob = 4'($urandom);
            v.prd = 6'($urandom);
            v = model(v);
            run_vec(v, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/csr_exec_pipe.md
# csr_exec_pipe

Registered, flow-controlled CSR execution unit for the out-of-order core, placed between the RCU issue port and the architectural CSR file and PMP unit. Accepts one CSR instruction via valid/ready and performs the read-modify-write in a dedicated execute cycle. Write suppression and illegal-encoding detection are per the privileged spec. Results go to a parametrised response FIFO drained by the RCU with backpressure. PMP register count is a parameter, and the unit honours pipeline flushes.

## Interface
Parameters:
- XLEN, 64, datapath width (32 or 64)
- ROB_INDEX_WIDTH, 4, ROB tag width
- PHY_REG_ADDR_WIDTH, 6, physical destination register width
- CSR_ADDR_LEN, 12, CSR address width
- IMM_LEN, 5, zimm width
- EXCEPTION_CAUSE_WIDTH, 4, cause width
- PMP_ENTRIES, 16, PMP regions (multiple of 8, ≤64)
- RESP_DEPTH, 2, response FIFO depth (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid_i / req_ready_o  in/out  1  request handshake
- rob_index_i  in  ROB_INDEX_WIDTH  tag
- prd_addr_i  in  PHY_REG_ADDR_WIDTH  destination
- func3_i  in  3  CSR op
- prs1_data_i  in  XLEN  rs1 value
- rs1_is_x0_i  in  1  rs1 field is x0
- imm_i  in  IMM_LEN  zimm
- csr_addr_i  in  CSR_ADDR_LEN  target CSR
- csr_do_read_i / csr_do_write_i  in  1  decoder read/write intent
- flush_i  in  1  kill all in-flight work
- csr_raddr_o  out  CSR_ADDR_LEN; csr_rdata_i, csr_readable_i, csr_writable_i  in  (same-cycle combinational read)
- csr_wen_o  out  1; csr_waddr_o  out  CSR_ADDR_LEN; csr_wdata_o  out  XLEN
- pmp_cfg_vld_o  out  1; pmp_cfg_addr_o  out  clog2(PMP_ENTRIES/8)+1; pmp_cfg_payload_o  out  XLEN; pmp_cfg_origin_payload_i  in  XLEN
- pmp_addr_vld_o  out  1; pmp_addr_addr_o  out  clog2(PMP_ENTRIES); pmp_addr_payload_o  out  XLEN; pmp_addr_origin_payload_i  in  XLEN
- resp_valid_o out 1, resp_ready_i in 1, resp_rob_index_o, resp_prd_addr_o, resp_data_o (XLEN), resp_exception_o (1), resp_ecause_o  response port (FIFO head)

## Operation
- FSM: IDLE, EXEC.
  - IDLE→EXEC on req_valid_i & req_ready_o; all request fields latched.
  - EXEC→IDLE unconditionally.
- req_ready_o = (state==IDLE) & (fifo_count < RESP_DEPTH).
- EXEC decode from latched fields:
  - is_pmpcfg: addr in [0x3A0, 0x3A0+PMP_ENTRIES/4).
  - is_pmpaddr: addr in [0x3B0, 0x3B0+PMP_ENTRIES).
  - old value = pmp_cfg_origin_payload_i / pmp_addr_origin_payload_i / csr_rdata_i respectively.
- Effective write eff_wr = csr_do_write_i, cleared when:
  - func3 ∈ {010, 011} and rs1_is_x0;
  - func3 ∈ {110, 111} and zimm==0.
- Illegal, ecause=2, on any of:
  - func3 ∈ {000, 100};
  - csr_do_read & ~readable;
  - eff_wr & ~writable;
  - XLEN==64 & is_pmpcfg & odd address.
- New value:
  - 001: rs1
  - 010: old|rs1
  - 011: old&~rs1
  - 101: zext(zimm)
  - 110: old|zimm
  - 111: old&~zimm
- Commit (csr_wen_o=1) only when EXEC & eff_wr & legal & ~flush_i.
- Commit routing:
  - pmpcfg: pmp_cfg_vld_o (not csr_wen_o); pmp_cfg_addr_o = index>>1.
  - pmpaddr: pmp_addr_vld_o; pmp_addr_addr_o = addr−0x3B0.
- Payload/wdata outputs carry the new value.
- Response push in EXEC unless flush_i: {rob, prd, data = legal ? old : 0, exception, ecause}.
- FIFO: circular, pop on resp_valid_o & resp_ready_i; push and pop in the same cycle are both allowed.
- flush_i:
  - forces state to IDLE next cycle and clears the FIFO (count, pointers);
  - blocks commit and push in the current cycle;
  - flush_i has priority over a simultaneous handshake (request dropped, state stays IDLE).

## Timing
- Reset values:
  - state IDLE; FIFO empty; req_ready_o=1;
  - resp_valid_o=0, csr_wen_o=0, pmp_*_vld_o=0;
  - all data/address outputs 0.
- Accept at cycle N → raddr and commit strobe during N+1 (single cycle) → resp_valid_o at N+2.
- Throughput: one request per 2 cycles with no backpressure.
- FIFO full (count==RESP_DEPTH) holds req_ready_o low; a request already in EXEC always has a slot, because acceptance required space.
- csr_raddr_o is driven from latched address, constant through EXEC.
- Outputs other than the commit strobes and payloads are registered.

## Test plan
- Reset asserted mid-EXEC with a CSRRW pending → csr_wen_o drops immediately, FIFO empty, req_ready_o=1 after release.
- CSRRW to 0x300, old=0xA, rs1=0x5 → wen at N+1 with wdata=0x5; response data 0xA at N+2.
- CSRRS with rs1_is_x0=1 to a read-only CSR (writable=0) → no wen, no exception; CSRRSI with zimm=3 → exception, ecause=2, data 0.
- PMP_ENTRIES=16, XLEN=64:
  - CSRRW 0x3A2 → pmp_cfg_vld_o with addr=1;
  - 0x3A1 → illegal;
  - CSRRC 0x3B5 → pmp_addr_addr_o=5, payload=old&~rs1.
- RESP_DEPTH=2, resp_ready_i=0, three back-to-back requests → third stalls (req_ready_o=0) until one pop; FIFO order preserved.
- flush_i during EXEC with a FIFO entry pending → no commit, resp_valid_o=0 next cycle, next request accepted normally.
